timing_skew_monitor: RTL

TIMING_SKEW_MONITOR -- requirements
Module: timing_skew_monitor

---
 rtl/timing_skew_monitor.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/timing_skew_monitor.sv
// Measures completion skew between two multiplier copies and accumulates leak statistics.
// Optional macro SKEW_WINNER_EN adds per-copy "finished first" counters.
module timing_skew_monitor #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned SKEW_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              doneOne,
    input  logic              doneTwo,
    input  logic              clear,
    output logic              busy,
    output logic              resultValid,
    output logic [SKEW_W-1:0] lastSkew,
    output logic              lastTimeout,
    output logic [SKEW_W-1:0] maxSkew,
    output logic [CNT_W-1:0]  trialCount,
    output logic [CNT_W-1:0]  leakCount,
    output logic              leakSticky
`ifdef SKEW_WINNER_EN
    ,
    output logic [CNT_W-1:0]  winOneCount,
    output logic [CNT_W-1:0]  winTwoCount
`endif
);

    localparam logic [SKEW_W-1:0] SKEW_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [SKEW_W-1:0] WAIT_END = SKEW_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FIRST, WAIT_SECOND, REPORT} state_e;

    state_e             state_q, state_d;
    logic [SKEW_W-1:0]  skew_q, skew_d, skew_inc;
    logic [SKEW_W-1:0]  wait_q, wait_d;
    logic               timeout_q, timeout_d;
    logic               first_two_q, first_two_d;
    logic               busy_q, busy_d;
    logic               result_valid_q, result_valid_d;
    logic [SKEW_W-1:0]  last_skew_q, last_skew_d;
    logic               last_timeout_q, last_timeout_d;
    logic [SKEW_W-1:0]  max_skew_q, max_skew_d;
    logic [CNT_W-1:0]   trial_cnt_q, trial_cnt_d;
    logic [CNT_W-1:0]   leak_cnt_q, leak_cnt_d;
    logic               leak_sticky_q, leak_sticky_d;
    logic               wait_last, leak;
`ifdef SKEW_WINNER_EN
    logic               have_first_q, have_first_d;
    logic [CNT_W-1:0]   win_one_q, win_one_d;
    logic [CNT_W-1:0]   win_two_q, win_two_d;
`endif

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Next-state, trial measurement and statistics update
    always_comb begin
        state_d        = state_q;
        skew_d         = skew_q;
        wait_d         = wait_q;
        timeout_d      = timeout_q;
        first_two_d    = first_two_q;
        last_skew_d    = last_skew_q;
        last_timeout_d = last_timeout_q;
        max_skew_d     = max_skew_q;
        trial_cnt_d    = trial_cnt_q;
        leak_cnt_d     = leak_cnt_q;
        leak_sticky_d  = leak_sticky_q;
`ifdef SKEW_WINNER_EN
        have_first_d   = have_first_q;
        win_one_d      = win_one_q;
        win_two_d      = win_two_q;
`endif
        skew_inc  = (skew_q == SKEW_MAX) ? skew_q : skew_q + SKEW_W'(1);
        wait_last = (wait_q == WAIT_END);
        leak      = (skew_q != '0) || timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = WAIT_FIRST;
                    skew_d      = '0;
                    wait_d      = '0;
                    timeout_d   = 1'b0;
                    first_two_d = 1'b0;
`ifdef SKEW_WINNER_EN
                    have_first_d = 1'b0;
`endif
                end
            end
            WAIT_FIRST: begin
                wait_d = wait_q + SKEW_W'(1);
                if (doneOne && doneTwo) begin
                    state_d = REPORT;
                end else begin
                    if (doneOne || doneTwo) begin
                        state_d     = WAIT_SECOND;
                        first_two_d = doneTwo;
`ifdef SKEW_WINNER_EN
                        have_first_d = 1'b1;
`endif
                    end
                    if (wait_last) begin
                        state_d   = REPORT;
                        timeout_d = 1'b1;
                    end
                end
            end
            WAIT_SECOND: begin
                wait_d = wait_q + SKEW_W'(1);
                skew_d = skew_inc;
                if (first_two_q ? doneOne : doneTwo) begin
                    state_d = REPORT;
                end else if (wait_last) begin
                    state_d   = REPORT;
                    timeout_d = 1'b1;
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Result is published on entry to REPORT; statistics fold in on leaving it
        if (state_d == REPORT) begin
            last_skew_d    = skew_d;
            last_timeout_d = timeout_d;
        end

        if (clear) begin
            max_skew_d    = '0;
            trial_cnt_d   = '0;
            leak_cnt_d    = '0;
            leak_sticky_d = 1'b0;
`ifdef SKEW_WINNER_EN
            win_one_d     = '0;
            win_two_d     = '0;
`endif
        end else if (state_q == REPORT) begin
            trial_cnt_d = cnt_inc(trial_cnt_q);
            if (leak) begin
                leak_cnt_d    = cnt_inc(leak_cnt_q);
                leak_sticky_d = 1'b1;
            end
            if (skew_q > max_skew_q) begin
                max_skew_d = skew_q;
            end
`ifdef SKEW_WINNER_EN
            if (have_first_q && !first_two_q) begin
                win_one_d = cnt_inc(win_one_q);
            end
            if (have_first_q && first_two_q) begin
                win_two_d = cnt_inc(win_two_q);
            end
`endif
        end

        result_valid_d = (state_d == REPORT);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            skew_q         <= '0;
            wait_q         <= '0;
            timeout_q      <= 1'b0;
            first_two_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            last_skew_q    <= '0;
            last_timeout_q <= 1'b0;
            max_skew_q     <= '0;
            trial_cnt_q    <= '0;
            leak_cnt_q     <= '0;
            leak_sticky_q  <= 1'b0;
`ifdef SKEW_WINNER_EN
            have_first_q   <= 1'b0;
            win_one_q      <= '0;
            win_two_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            skew_q         <= skew_d;
            wait_q         <= wait_d;
            timeout_q      <= timeout_d;
            first_two_q    <= first_two_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            last_skew_q    <= last_skew_d;
            last_timeout_q <= last_timeout_d;
            max_skew_q     <= max_skew_d;
            trial_cnt_q    <= trial_cnt_d;
            leak_cnt_q     <= leak_cnt_d;
            leak_sticky_q  <= leak_sticky_d;
`ifdef SKEW_WINNER_EN
            have_first_q   <= have_first_d;
            win_one_q      <= win_one_d;
            win_two_q      <= win_two_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign resultValid = result_valid_q;
    assign lastSkew    = last_skew_q;
    assign lastTimeout = last_timeout_q;
    assign maxSkew     = max_skew_q;
    assign trialCount  = trial_cnt_q;
    assign leakCount   = leak_cnt_q;
    assign leakSticky  = leak_sticky_q;
`ifdef SKEW_WINNER_EN
    assign winOneCount = win_one_q;
    assign winTwoCount = win_two_q;
`endif

endmodule
